dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Posted-write buffer sitting downstream of the processor's memory stage, between the core's dmem port and a slow, handshaked data memory.
- Accepts stores in a single cycle and queues them in order.
- Drains them to memory with a req/ack protocol.
- Forwards buffered data to loads so the core sees its own pending stores.

Parameters:
- DEPTH, 4, number of store entries (power of two, >=2)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- cpu_wren  in  1  store request from the memory stage
- cpu_addr  in  ADDR_W  store address, also the load lookup address
- cpu_wdata  in  DATA_W  store data
- full  out  1  buffer cannot accept a store this cycle
- fwd_hit  out  1  a buffered store matches cpu_addr
- fwd_data  out  DATA_W  data of the youngest matching entry
- mem_req  out  1  write request to memory
- mem_addr  out  ADDR_W  head entry address
- mem_wdata  out  DATA_W  head entry data
- mem_ack  in  1  memory accepted the current write
- empty  out  1  no valid entries and mem_req low
- overflow  out  1  sticky: a store arrived while full

Behaviour:
- Storage: circular FIFO of DEPTH entries {valid, addr, data}.
  - head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is 0..DEPTH.
- Reset (reset==0, asynchronous): clear all valid bits, head=tail=count=0, state=IDLE, mem_req=0, overflow=0.
  - An in-flight write is abandoned. The memory side must tolerate a req drop.
- full = (count==DEPTH), combinational from registered state.
- Enqueue on a rising edge when cpu_wren=1 and full=0.
  - Merge case: if the youngest valid entry (tail-1) has addr==cpu_addr and is not the head entry currently under request, overwrite its data. tail and count are unchanged.
  - Otherwise write the entry at tail, then tail++ and count++.
- cpu_wren=1 while full=1: the store is dropped, overflow is set and stays set until reset.
  - A same-cycle mem_ack does not make room for it.
- Forwarding is combinational over registered entries only.
  - fwd_hit=1 if any valid entry matches cpu_addr.
  - fwd_data is the youngest matching entry (closest to tail); 0 when there is no hit.
  - A store enqueued in the current cycle is not forwarded until the next cycle.
- Drain FSM (mem_req is a registered output):
  - IDLE: mem_req=0. If count>0 at the edge, go to REQ.
  - REQ: mem_req=1; mem_addr/mem_wdata = head entry, held stable until ack.
  - On an edge with mem_ack=1 in REQ: invalidate head, head++, count--.
    - If count after pop >0, stay in REQ. The next head is presented the following cycle, giving back-to-back writes at 1 per cycle.
    - Otherwise go to IDLE.
  - mem_ack outside REQ is ignored.
- Simultaneous enqueue and pop in the same edge: count is unchanged, both pointers advance.
- Latency: a store accepted at edge N raises mem_req no earlier than the cycle after edge N+1 when the buffer was empty (IDLE->REQ on edge N+1).
- empty = (count==0) & ~mem_req.
- Ordering: memory sees stores in program order. Merging only ever updates the youngest entry, so ordering is preserved.
- mem_addr/mem_wdata are 0 when mem_req=0.

Test Plan:
- Reset mid-drain: enqueue 0x10/0xAA, assert reset=0 while mem_req=1 -> mem_req drops immediately, empty=1, fwd_hit=0 for 0x10, overflow=0.
- Single store: cpu_wren with addr 0x20/data 0x1234 at edge 1, mem_ack held 1 -> mem_req=1 with 0x20/0x1234 after edge 2; popped at edge 3; empty=1 after.
- Fill and overflow: mem_ack=0, four stores to 0x1..0x4 -> full=1. A fifth store (0x5) -> overflow=1, count stays 4. Release ack -> memory receives 0x1,0x2,0x3,0x4 in order, 0x5 never appears.
- Forwarding priority: stores 0x40/0x11 then 0x44/0x22 then 0x40/0x33 (no merge: 0x44 is youngest when 0x40/0x33 arrives) -> lookup 0x40 gives fwd_hit=1, fwd_data=0x33; lookup 0x48 gives fwd_hit=0, fwd_data=0.
- Merge vs in-flight head: with ack held 0, store 0x50/0x01 (becomes the requested head), then 0x50/0x02 -> a new entry is allocated and count=2. A third store 0x50/0x03 merges into the youngest entry and count stays 2. Memory receives 0x01 then 0x03.
- Wrap-around with concurrent enqueue/pop: 10 stores to distinct addresses while ack toggles 1/0 each cycle -> pointers wrap past DEPTH, count never exceeds 4, memory sequence equals the input sequence, overflow=0.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer: stores accepted in 1 cycle, drained in order over req/ack; mem_req rises one edge after the first store.
// Backpressure: full_o while DEPTH entries are pending; a store seen while full is dropped and sets sticky overflow_o.
module dmem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_wren_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              full_o,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    output logic              empty_o,
    output logic              overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_REQ  = 1'b1;

    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              state_q, state_d;
    logic              overflow_q, overflow_d;

    logic [PTR_W-1:0]  youngest;
    logic [PTR_W-1:0]  scan_idx;
    logic              is_full, in_req, pop, push, merge, alloc;

    always_comb begin
        youngest = tail_q - PTR_W'(1);
        is_full  = (count_q == CNT_FULL);
        in_req   = (state_q == STATE_REQ);
        pop      = in_req & mem_ack_i;
        push     = cpu_wren_i & ~is_full;
        // Never merge into the entry memory is currently sampling.
        merge    = push & (count_q != '0) & valid_q[youngest]
                 & (addr_q[youngest] == cpu_addr_i)
                 & ~(in_req & (youngest == head_q));
        alloc    = push & ~merge;
    end

    always_comb begin
        head_d     = pop   ? head_q + PTR_W'(1) : head_q;
        tail_d     = alloc ? tail_q + PTR_W'(1) : tail_q;
        count_d    = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);
        overflow_d = overflow_q | (cpu_wren_i & is_full);
        state_d    = state_q;
        case (state_q)
            STATE_IDLE: if (count_q != '0) state_d = STATE_REQ;
            STATE_REQ:  if (pop && count_d == '0) state_d = STATE_IDLE;
            default:    state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= STATE_IDLE;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
            if (pop)
                valid_q[head_q] <= 1'b0;
            if (merge)
                data_q[youngest] <= cpu_wdata_i;
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= cpu_addr_i;
                data_q[tail_q]  <= cpu_wdata_i;
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        scan_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if (valid_q[scan_idx] && addr_q[scan_idx] == cpu_addr_i) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[scan_idx];
            end
        end
    end

    assign full_o      = is_full;
    assign mem_req_o   = in_req;
    assign mem_addr_o  = in_req ? addr_q[head_q] : '0;
    assign mem_wdata_o = in_req ? data_q[head_q] : '0;
    assign empty_o     = (count_q == '0) & ~in_req;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomised and directed bench for dmem_store_buffer against a queue-based reference model.
module tb_dmem_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wren = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        full, fwd_hit, mem_req, empty, overflow;
    logic [31:0] fwd_data, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cpu_wren_i  (wren),
        .cpu_addr_i  (addr),
        .cpu_wdata_i (wdata),
        .full_o      (full),
        .fwd_hit_o   (fwd_hit),
        .fwd_data_o  (fwd_data),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (ack),
        .empty_o     (empty),
        .overflow_o  (overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];      // pending stores, oldest first
    bit          m_req;      // model: a write is being offered to memory
    bit          m_ovf;
    logic [63:0] wlog[$];    // writes memory actually accepted from the DUT
    logic [63:0] exp_seq[$];
    int          n_chk = 0;
    int          n_err = 0;

    task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit          e_hit = 1'b0;
        logic [31:0] e_fd = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == addr) begin
                e_hit = 1'b1;
                e_fd  = mq[i].d;
                break;
            end
        end
        check_val("full",     full,     64'(mq.size() == DEPTH));
        check_val("fwd_hit",  fwd_hit,  64'(e_hit));
        check_val("fwd_data", fwd_data, 64'(e_fd));
        check_val("mem_req",  mem_req,  64'(m_req));
        check_val("mem_addr", mem_addr, 64'((m_req && mq.size() > 0) ? mq[0].a : 32'h0));
        check_val("mem_wdata", mem_wdata, 64'((m_req && mq.size() > 0) ? mq[0].d : 32'h0));
        check_val("empty",    empty,    64'(mq.size() == 0 && !m_req));
        check_val("overflow", overflow, 64'(m_ovf));
    endtask

    // One clock: drive at negedge, check before the edge, advance the model at the edge.
    task automatic cycle(bit w, logic [31:0] a, logic [31:0] d, bit k);
        bit   full_m, pop, push, merge;
        int   sz0;
        ent_t e;
        wren = w; addr = a; wdata = d; ack = k;
        #1;
        check_outputs();
        if (mem_req && ack) wlog.push_back({mem_addr, mem_wdata});
        @(posedge clk);
        full_m = (mq.size() == DEPTH);
        sz0    = mq.size();
        pop    = m_req && k;
        push   = w && !full_m;
        merge  = push && sz0 > 0 && mq[sz0-1].a == a && !(m_req && sz0 == 1);
        if (w && full_m) m_ovf = 1'b1;
        if (pop) void'(mq.pop_front());
        if (merge) begin
            e = mq[mq.size()-1];
            e.d = d;
            mq[mq.size()-1] = e;
        end else if (push) begin
            e.a = a;
            e.d = d;
            mq.push_back(e);
        end
        if (!m_req) m_req = (sz0 > 0);
        else if (pop) m_req = (mq.size() > 0);
        @(negedge clk);
    endtask

    task automatic probe(logic [31:0] a);
        wren = 1'b0; ack = 1'b0; addr = a;
        #1;
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic do_reset(logic [31:0] look);
        wren = 1'b0; ack = 1'b0; addr = look;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_req",   mem_req,  0);
        check_val("rst_empty", empty,    1);
        check_val("rst_hit",   fwd_hit,  0);
        check_val("rst_ovf",   overflow, 0);
        check_val("rst_full",  full,     0);
        mq.delete();
        m_req = 1'b0;
        m_ovf = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_log(string tag);
        check_val({tag, "_len"}, 64'(wlog.size()), 64'(exp_seq.size()));
        for (int i = 0; i < wlog.size() && i < exp_seq.size(); i++)
            check_val(tag, wlog[i], exp_seq[i]);
    endtask

    initial begin
        int sent;
        logic [31:0] d;

        do_reset(32'h0);

        // Reset while a write is being offered.
        cycle(1'b1, 32'h10, 32'hAA, 1'b0);
        cycle(1'b0, 32'h10, 32'h0, 1'b0);
        probe(32'h10);
        check_val("md_req_pre", mem_req, 1);
        do_reset(32'h10);

        // Single store, ack held high.
        wlog.delete();
        cycle(1'b1, 32'h20, 32'h1234, 1'b1);
        probe(32'h20);
        check_val("single_req_e1", mem_req, 0);
        cycle(1'b0, 32'h20, 32'h0, 1'b1);
        probe(32'h20);
        check_val("single_req_e2", mem_req, 1);
        check_val("single_addr", mem_addr, 32'h20);
        check_val("single_data", mem_wdata, 32'h1234);
        cycle(1'b0, 32'h20, 32'h0, 1'b1);
        probe(32'h20);
        check_val("single_empty", empty, 1);

        // Fill, then one store too many.
        wlog.delete();
        exp_seq.delete();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 32'(i), 32'h100 + 32'(i), 1'b0);
            exp_seq.push_back({32'(i), 32'h100 + 32'(i)});
        end
        probe(32'h0);
        check_val("fill_full", full, 1);
        cycle(1'b1, 32'h5, 32'h105, 1'b0);
        probe(32'h5);
        check_val("ovf_set", overflow, 1);
        check_val("ovf_nofwd", fwd_hit, 0);
        drain(8);
        check_log("fill_seq");
        do_reset(32'h0);

        // Forwarding picks the youngest match.
        cycle(1'b1, 32'h40, 32'h11, 1'b0);
        cycle(1'b1, 32'h44, 32'h22, 1'b0);
        cycle(1'b1, 32'h40, 32'h33, 1'b0);
        probe(32'h40);
        check_val("fwd40_hit", fwd_hit, 1);
        check_val("fwd40_data", fwd_data, 32'h33);
        probe(32'h48);
        check_val("fwd48_hit", fwd_hit, 0);
        check_val("fwd48_data", fwd_data, 32'h0);
        drain(6);

        // Merge must skip the in-flight head but hit a later youngest entry.
        wlog.delete();
        exp_seq.delete();
        cycle(1'b1, 32'h50, 32'h01, 1'b0);
        cycle(1'b0, 32'h50, 32'h00, 1'b0);
        cycle(1'b1, 32'h50, 32'h02, 1'b0);
        cycle(1'b1, 32'h50, 32'h03, 1'b0);
        probe(32'h50);
        check_val("merge_data", fwd_data, 32'h03);
        check_val("merge_full", full, 0);
        drain(6);
        exp_seq.push_back({32'h50, 32'h01});
        exp_seq.push_back({32'h50, 32'h03});
        check_log("merge_seq");

        // Ten distinct stores while ack toggles; pointers wrap.
        wlog.delete();
        exp_seq.delete();
        sent = 0;
        for (int c = 0; c < 60 && sent < 10; c++) begin
            if (mq.size() < DEPTH) begin
                d = $urandom;
                exp_seq.push_back({32'h100 + 32'(sent * 4), d});
                cycle(1'b1, 32'h100 + 32'(sent * 4), d, (c % 2) == 0);
                sent++;
            end else begin
                cycle(1'b0, 32'h0, 32'h0, (c % 2) == 0);
            end
        end
        drain(8);
        probe(32'h0);
        check_val("wrap_ovf", overflow, 0);
        check_val("wrap_empty", empty, 1);
        check_log("wrap_seq");

        // Random traffic on a small address set to exercise merges and hits.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset(32'h200);
            cycle($urandom_range(0, 9) < 6,
                  32'h200 + 32'($urandom_range(0, 5) * 4),
                  $urandom,
                  $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
